// File: rtl/calc_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg: shared types for the calculator datapath.
//   num_t         : decimal floating operand (error, sign, exponent, BCD digits)
//   key_t         : keypad key codes (code 15 is reserved)
//   entry_state_t : operand-entry FSM states
//   CntW          : width of a digit counter able to hold 0..NumDigits
// -----------------------------------------------------------------------------
package calc_pkg;

  localparam int NumDigits = 8;
  localparam int ExpW      = 8;
  localparam int CntW      = $clog2(NumDigits + 1);

  typedef logic signed [ExpW-1:0] exp_t;

  // value = (-1)^sign * d[N-1].d[N-2]..d[0] * 10^exponent
  typedef struct packed {
    logic                      error;
    logic                      sign;
    exp_t                      exponent;
    logic [NumDigits-1:0][3:0] digits;
  } num_t;

  typedef enum logic [3:0] {
    KEY_0     = 4'd0,
    KEY_1     = 4'd1,
    KEY_2     = 4'd2,
    KEY_3     = 4'd3,
    KEY_4     = 4'd4,
    KEY_5     = 4'd5,
    KEY_6     = 4'd6,
    KEY_7     = 4'd7,
    KEY_8     = 4'd8,
    KEY_9     = 4'd9,
    KEY_POINT = 4'd10,
    KEY_SIGN  = 4'd11,
    KEY_BACK  = 4'd12,
    KEY_CLEAR = 4'd13,
    KEY_ENTER = 4'd14
  } key_t;

  typedef enum logic [1:0] {
    INT  = 2'd0,
    FRAC = 2'd1,
    DONE = 2'd2
  } entry_state_t;

endpackage

// File: rtl/num_entry.sv
// -----------------------------------------------------------------------------
// num_entry: keypad operand assembler feeding the ALU.
// Collects key codes over a valid/ready handshake into a BCD entry buffer and,
// on ENTER, presents the finished operand on a valid/ready output.
// Ports:
//   clk_i        clock
//   rst_i        asynchronous active-high reset
//   key_i        key code (calc_pkg::key_t)
//   key_valid_i  key code present
//   key_ready_o  block can accept a key (low while an operand is pending)
//   num_o        assembled operand (registered)
//   num_valid_o  num_o valid (registered)
//   num_ready_i  downstream accepts num_o
// -----------------------------------------------------------------------------
module num_entry
  import calc_pkg::*;
#(
  parameter int NumDigits = calc_pkg::NumDigits
) (
  input  logic clk_i,
  input  logic rst_i,
  input  key_t key_i,
  input  logic key_valid_i,
  output logic key_ready_o,
  output num_t num_o,
  output logic num_valid_o,
  input  logic num_ready_i
);

  localparam int CW = $clog2(NumDigits + 1);
  localparam int IW = (NumDigits > 2) ? $clog2(NumDigits) : 1;

  typedef logic [CW-1:0] cnt_t;
  typedef logic [IW-1:0] idx_t;
  typedef logic [NumDigits-1:0][3:0] dbuf_t;

  entry_state_t state, state_n;
  logic         sign, sign_n;
  cnt_t         int_cnt, int_n;
  cnt_t         frac_cnt, frac_n;
  cnt_t         tot_cnt, tot_n;
  dbuf_t        dbuf, dbuf_n;
  num_t         num_q, num_n;
  logic         valid_q, valid_n;

  logic         accept;
  logic         room;
  logic [3:0]   kval;
  idx_t         wr_idx;
  idx_t         bk_idx;

  assign accept = key_valid_i && (state != DONE);
  assign room   = (tot_cnt < cnt_t'(NumDigits));
  assign kval   = key_i;
  // Next free slot counted from the most significant digit.
  assign wr_idx = idx_t'(NumDigits - 1) - idx_t'(tot_cnt);
  // Most recently written slot (only used while tot_cnt > 0).
  assign bk_idx = idx_t'(NumDigits) - idx_t'(tot_cnt);

  assign key_ready_o = (state != DONE);
  assign num_o       = num_q;
  assign num_valid_o = valid_q;

  // State and entry registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= INT;
      sign     <= 1'b0;
      int_cnt  <= '0;
      frac_cnt <= '0;
      tot_cnt  <= '0;
      dbuf     <= '0;
      num_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      state    <= state_n;
      sign     <= sign_n;
      int_cnt  <= int_n;
      frac_cnt <= frac_n;
      tot_cnt  <= tot_n;
      dbuf     <= dbuf_n;
      num_q    <= num_n;
      valid_q  <= valid_n;
    end
  end

  // Key decoding, entry update and output handshake.
  always_comb begin
    state_n = state;
    sign_n  = sign;
    int_n   = int_cnt;
    frac_n  = frac_cnt;
    tot_n   = tot_cnt;
    dbuf_n  = dbuf;
    num_n   = num_q;
    valid_n = valid_q;

    case (state)
      INT, FRAC: begin
        if (accept) begin
          case (key_i)
            KEY_0, KEY_1, KEY_2, KEY_3, KEY_4,
            KEY_5, KEY_6, KEY_7, KEY_8, KEY_9: begin
              if (state == INT && kval == 4'd0 && int_cnt == cnt_t'(0)) begin
                // Leading zero: swallowed so the ones digit stays nonzero.
                tot_n = tot_cnt;
              end else if (room) begin
                dbuf_n[wr_idx] = kval;
                tot_n          = tot_cnt + cnt_t'(1);
                if (state == INT) begin
                  int_n = int_cnt + cnt_t'(1);
                end else begin
                  frac_n = frac_cnt + cnt_t'(1);
                end
              end else begin
                // Buffer full: key consumed, digit dropped.
                tot_n = tot_cnt;
              end
            end
            KEY_POINT: begin
              if (state == INT) begin
                state_n = FRAC;
                // No integer digits yet: reserve the implicit ones digit 0.
                if (int_cnt == cnt_t'(0)) begin
                  tot_n = cnt_t'(1);
                end else begin
                  tot_n = tot_cnt;
                end
              end else begin
                state_n = state;
              end
            end
            KEY_BACK: begin
              if (state == FRAC) begin
                if (frac_cnt != cnt_t'(0)) begin
                  dbuf_n[bk_idx] = 4'd0;
                  frac_n         = frac_cnt - cnt_t'(1);
                  tot_n          = tot_cnt - cnt_t'(1);
                end else begin
                  state_n = INT;
                  // Drop the implicit ones digit reserved by the point.
                  if (int_cnt == cnt_t'(0)) begin
                    tot_n = cnt_t'(0);
                  end else begin
                    tot_n = tot_cnt;
                  end
                end
              end else if (int_cnt != cnt_t'(0)) begin
                dbuf_n[bk_idx] = 4'd0;
                int_n          = int_cnt - cnt_t'(1);
                tot_n          = tot_cnt - cnt_t'(1);
              end else begin
                int_n = int_cnt;
              end
            end
            KEY_SIGN: begin
              sign_n = ~sign;
            end
            KEY_CLEAR: begin
              state_n = INT;
              sign_n  = 1'b0;
              int_n   = '0;
              frac_n  = '0;
              tot_n   = '0;
              dbuf_n  = '0;
            end
            KEY_ENTER: begin
              num_n.error    = 1'b0;
              num_n.digits   = dbuf;
              num_n.exponent = (int_cnt == cnt_t'(0)) ? exp_t'(0)
                                                      : exp_t'(int_cnt - cnt_t'(1));
              // Negative zero is normalised to plain zero.
              num_n.sign     = sign && (dbuf != '0);
              valid_n        = 1'b1;
              state_n        = DONE;
            end
            default: begin
              // Reserved code: consumed without effect.
              state_n = state;
            end
          endcase
        end else begin
          state_n = state;
        end
      end
      DONE: begin
        if (num_ready_i) begin
          valid_n = 1'b0;
          state_n = INT;
          sign_n  = 1'b0;
          int_n   = '0;
          frac_n  = '0;
          tot_n   = '0;
          dbuf_n  = '0;
        end else begin
          valid_n = valid_q;
        end
      end
      default: begin
        state_n = INT;
      end
    endcase
  end

endmodule
